// File: rtl/selective_flush_pipe_reg_pkg.sv
// Shared types and the wrap-aware flush range test used by selective_flush_pipe_reg.
// The optional killed-op statistic is enabled with RSD_PIPE_REG_FLUSH_STAT_EN.
package selective_flush_pipe_reg_pkg;

  // Widest active-list pointer the shared range function accepts.
  localparam int PTR_MAX = 16;

  typedef struct packed {
    logic stall;
    logic clear;
  } pipeline_control_t;

  // head==tail is the empty range; head>tail wraps past the top of the active list.
  function automatic logic range_hit(input logic [PTR_MAX-1:0] p,
                                     input logic [PTR_MAX-1:0] head,
                                     input logic [PTR_MAX-1:0] tail);
    logic hit;
    hit = 1'b0;
    if (head < tail) begin
      hit = (p >= head) && (p < tail);
    end else if (head > tail) begin
      hit = (p >= head) || (p < tail);
    end
    return hit;
  endfunction

endpackage

// File: rtl/selective_flush_range_check.sv
// Combinational per-lane flush hit vector for one row of pipeline slots.
// The vector is already gated by flush_valid.
module selective_flush_range_check
  import selective_flush_pipe_reg_pkg::*;
#(
  parameter int LANES     = 2,
  parameter int PTR_WIDTH = 6
) (
  input  logic [LANES*PTR_WIDTH-1:0] ptr,
  input  logic [PTR_WIDTH-1:0]       head,
  input  logic [PTR_WIDTH-1:0]       tail,
  input  logic                       flush_valid,
  output logic [LANES-1:0]           hit
);

  always_comb begin
    hit = '0;
    for (int l = 0; l < LANES; l++) begin
      hit[l] = flush_valid & range_hit(PTR_MAX'(ptr[l*PTR_WIDTH +: PTR_WIDTH]),
                                       PTR_MAX'(head), PTR_MAX'(tail));
    end
  end

endmodule

// File: rtl/selective_flush_pipe_reg.sv
// Multi-lane, multi-stage pipeline register with stall, clear and selective flush.
// Define RSD_PIPE_REG_FLUSH_STAT_EN to add the saturating flushCount output.
module selective_flush_pipe_reg
  import selective_flush_pipe_reg_pkg::*;
#(
  parameter int LANES      = 2,
  parameter int DEPTH      = 2,
  parameter int DATA_WIDTH = 32,
  parameter int PTR_WIDTH  = 6
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           stall,
  input  logic                           clear,
  input  logic [LANES-1:0]               inValid,
  input  logic [LANES*PTR_WIDTH-1:0]     inPtr,
  input  logic [LANES*DATA_WIDTH-1:0]    inData,
  input  logic                           flushValid,
  input  logic [PTR_WIDTH-1:0]           flushHeadPtr,
  input  logic [PTR_WIDTH-1:0]           flushTailPtr,
  output logic [LANES-1:0]               outValid,
  output logic [LANES*PTR_WIDTH-1:0]     outPtr,
  output logic [LANES*DATA_WIDTH-1:0]    outData,
  output logic [$clog2(DEPTH*LANES+1)-1:0] occupancy
`ifdef RSD_PIPE_REG_FLUSH_STAT_EN
  ,
  output logic [15:0]                    flushCount
`endif
);

  localparam int OCC_W = $clog2(DEPTH*LANES+1);

  pipeline_control_t ctrl;
  assign ctrl = '{stall: stall, clear: clear};

  logic [LANES-1:0]            valid_q [DEPTH];
  logic [LANES*PTR_WIDTH-1:0]  ptr_q   [DEPTH];
  logic [LANES*DATA_WIDTH-1:0] data_q  [DEPTH];
  logic [LANES-1:0]            valid_d [DEPTH];
  logic [LANES-1:0]            hit_stage [DEPTH];
  logic [LANES-1:0]            hit_in;
  logic [OCC_W-1:0]            occ_q;
  logic [OCC_W-1:0]            occ_d;

  for (genvar s = 0; s < DEPTH; s++) begin : g_stage_check
    selective_flush_range_check #(.LANES(LANES), .PTR_WIDTH(PTR_WIDTH)) u_check (
      .ptr         (ptr_q[s]),
      .head        (flushHeadPtr),
      .tail        (flushTailPtr),
      .flush_valid (flushValid),
      .hit         (hit_stage[s])
    );
  end

  selective_flush_range_check #(.LANES(LANES), .PTR_WIDTH(PTR_WIDTH)) u_in_check (
    .ptr         (inPtr),
    .head        (flushHeadPtr),
    .tail        (flushTailPtr),
    .flush_valid (flushValid),
    .hit         (hit_in)
  );

  // Each written valid is its source valid filtered by the flush hit of that source.
  always_comb begin
    for (int s = 0; s < DEPTH; s++) begin
      valid_d[s] = '0;
    end
    occ_d = '0;
    if (ctrl.stall) begin
      for (int s = 0; s < DEPTH; s++) begin
        valid_d[s] = valid_q[s] & ~hit_stage[s];
      end
    end else begin
      valid_d[0] = inValid & ~hit_in;
      for (int s = 1; s < DEPTH; s++) begin
        valid_d[s] = valid_q[s-1] & ~hit_stage[s-1];
      end
    end
    for (int s = 0; s < DEPTH; s++) begin
      for (int l = 0; l < LANES; l++) begin
        occ_d = occ_d + OCC_W'(valid_d[s][l]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < DEPTH; s++) begin
        valid_q[s] <= '0;
        ptr_q[s]   <= '0;
        data_q[s]  <= '0;
      end
      occ_q <= '0;
    end else if (ctrl.clear) begin
      for (int s = 0; s < DEPTH; s++) begin
        valid_q[s] <= '0;
      end
      occ_q <= '0;
    end else begin
      for (int s = 0; s < DEPTH; s++) begin
        valid_q[s] <= valid_d[s];
      end
      if (!ctrl.stall) begin
        ptr_q[0]  <= inPtr;
        data_q[0] <= inData;
        for (int s = 1; s < DEPTH; s++) begin
          ptr_q[s]  <= ptr_q[s-1];
          data_q[s] <= data_q[s-1];
        end
      end
      occ_q <= occ_d;
    end
  end

  assign outValid  = valid_q[DEPTH-1];
  assign outPtr    = ptr_q[DEPTH-1];
  assign outData   = data_q[DEPTH-1];
  assign occupancy = occ_q;

`ifdef RSD_PIPE_REG_FLUSH_STAT_EN
  localparam int KILL_W = $clog2(DEPTH*LANES+LANES+1);

  logic [KILL_W-1:0] kill_cnt;
  logic [16:0]       fc_sum;
  logic [15:0]       fc_q;

  // A kill is counted only for a slot that would otherwise be written this cycle;
  // the last stage leaving the pipe on a shift is not a kill.
  always_comb begin
    kill_cnt = '0;
    for (int s = 0; s < DEPTH; s++) begin
      if (ctrl.stall || (s < DEPTH-1)) begin
        for (int l = 0; l < LANES; l++) begin
          kill_cnt = kill_cnt + KILL_W'(valid_q[s][l] & hit_stage[s][l]);
        end
      end
    end
    if (!ctrl.stall) begin
      for (int l = 0; l < LANES; l++) begin
        kill_cnt = kill_cnt + KILL_W'(inValid[l] & hit_in[l]);
      end
    end
    fc_sum = {1'b0, fc_q} + 17'(kill_cnt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fc_q <= '0;
    end else if (!ctrl.clear) begin
      fc_q <= fc_sum[16] ? 16'hFFFF : fc_sum[15:0];
    end
  end

  assign flushCount = fc_q;
`endif

endmodule

// File: tb/tb_selective_flush_pipe_reg.sv
// Directed bench for selective_flush_pipe_reg (LANES=2, DEPTH=2, PTR_WIDTH=6).
// flushCount checks compile in only with RSD_PIPE_REG_FLUSH_STAT_EN.
module tb_selective_flush_pipe_reg;

  logic        clk = 1'b0;
  logic        rst, stall, clear, flushValid;
  logic [1:0]  inValid;
  logic [11:0] inPtr;
  logic [63:0] inData;
  logic [5:0]  flushHeadPtr, flushTailPtr;
  logic [1:0]  outValid;
  logic [11:0] outPtr;
  logic [63:0] outData;
  logic [2:0]  occupancy;
`ifdef RSD_PIPE_REG_FLUSH_STAT_EN
  logic [15:0] flushCount;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int exp_fc   = 0;

  always #5 clk = ~clk;

  selective_flush_pipe_reg #(.LANES(2), .DEPTH(2), .DATA_WIDTH(32), .PTR_WIDTH(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .clear        (clear),
    .inValid      (inValid),
    .inPtr        (inPtr),
    .inData       (inData),
    .flushValid   (flushValid),
    .flushHeadPtr (flushHeadPtr),
    .flushTailPtr (flushTailPtr),
    .outValid     (outValid),
    .outPtr       (outPtr),
    .outData      (outData),
    .occupancy    (occupancy)
`ifdef RSD_PIPE_REG_FLUSH_STAT_EN
    ,
    .flushCount   (flushCount)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_fc(input string tag);
`ifdef RSD_PIPE_REG_FLUSH_STAT_EN
    check(tag, 64'(flushCount), 64'(exp_fc));
`endif
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [1:0] v, input logic [5:0] p1, input logic [5:0] p0,
                        input logic [31:0] d1, input logic [31:0] d0);
    inValid = v;
    inPtr   = {p1, p0};
    inData  = {d1, d0};
  endtask

  task automatic set_flush(input logic fv, input logic [5:0] h, input logic [5:0] t);
    flushValid   = fv;
    flushHeadPtr = h;
    flushTailPtr = t;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; clear = 1'b0;
    set_in(2'b00, 6'd0, 6'd0, 32'h0, 32'h0);
    set_flush(1'b0, 6'd0, 6'd0);
    step();
    step();
    check("rst_out_valid", 64'(outValid), 64'd0);
    check("rst_out_ptr", 64'(outPtr), 64'd0);
    check("rst_out_data", outData, 64'd0);
    check("rst_occ", 64'(occupancy), 64'd0);
    check_fc("rst_fc");
    rst = 1'b0;

    // Streaming, two-cycle latency
    set_in(2'b11, 6'd4, 6'd3, 32'hB1B1_0001, 32'hA0A0_0000);
    step();
    check("lat_out_valid_c1", 64'(outValid), 64'd0);
    check("lat_occ_c1", 64'(occupancy), 64'd2);
    set_in(2'b11, 6'd6, 6'd5, 32'hD3D3_0003, 32'hC2C2_0002);
    step();
    check("lat_out_valid_c2", 64'(outValid), 64'b11);
    check("lat_out_ptr_c2", 64'(outPtr), 64'({6'd4, 6'd3}));
    check("lat_out_data_c2", outData, {32'hB1B1_0001, 32'hA0A0_0000});
    check("lat_occ_c2", 64'(occupancy), 64'd4);
    set_in(2'b00, 6'd0, 6'd0, 32'h0, 32'h0);
    step();
    check("lat_out_ptr_c3", 64'(outPtr), 64'({6'd6, 6'd5}));
    check("lat_occ_c3", 64'(occupancy), 64'd2);
    step();
    check("drain_valid", 64'(outValid), 64'd0);
    check("drain_occ", 64'(occupancy), 64'd0);

    // Flush 11..19 on a held last stage holding 10/11
    set_in(2'b11, 6'd11, 6'd10, 32'h11, 32'h10);
    step();
    set_in(2'b00, 6'd0, 6'd0, 32'h0, 32'h0);
    step();
    check("fl_pre_valid", 64'(outValid), 64'b11);
    stall = 1'b1;
    set_flush(1'b1, 6'd11, 6'd20);
    step();
    stall = 1'b0;
    set_flush(1'b0, 6'd0, 6'd0);
    exp_fc = exp_fc + 1;
    check("fl_valid", 64'(outValid), 64'b01);
    check("fl_ptr", 64'(outPtr), 64'({6'd11, 6'd10}));
    check("fl_occ", 64'(occupancy), 64'd1);
    check_fc("fl_fc");

    // Wrap range 60..1: 63 and 1 killed, 2 and 59 survive
    set_in(2'b11, 6'd1, 6'd63, 32'h1, 32'h63);
    step();
    set_in(2'b11, 6'd59, 6'd2, 32'h59, 32'h2);
    set_flush(1'b1, 6'd60, 6'd2);
    step();
    exp_fc = exp_fc + 2;
    set_in(2'b00, 6'd0, 6'd0, 32'h0, 32'h0);
    set_flush(1'b0, 6'd0, 6'd0);
    check("wrap_kill_valid", 64'(outValid), 64'd0);
    check("wrap_occ", 64'(occupancy), 64'd2);
    check_fc("wrap_fc");
    step();
    check("wrap_keep_valid", 64'(outValid), 64'b11);
    check("wrap_keep_ptr", 64'(outPtr), 64'({6'd59, 6'd2}));
    step();

    // Empty range head==tail, then an incoming lane filtered by flush
    set_in(2'b11, 6'd5, 6'd5, 32'h55, 32'h50);
    set_flush(1'b1, 6'd5, 6'd5);
    step();
    check("empty_occ", 64'(occupancy), 64'd2);
    check_fc("empty_fc");
    set_in(2'b11, 6'd7, 6'd5, 32'h77, 32'h75);
    set_flush(1'b1, 6'd5, 6'd6);
    step();
    exp_fc = exp_fc + 3;
    set_in(2'b00, 6'd0, 6'd0, 32'h0, 32'h0);
    set_flush(1'b0, 6'd0, 6'd0);
    check("infl_valid", 64'(outValid), 64'd0);
    check("infl_occ", 64'(occupancy), 64'd1);
    check_fc("infl_fc");
    step();
    check("infl_out_valid", 64'(outValid), 64'b10);
    check("infl_out_data", outData[63:32], 64'h77);
    step();

    // Three-cycle stall on a full pipe with one held slot flushed
    set_in(2'b11, 6'd21, 6'd20, 32'hAAAA_0021, 32'hAAAA_0020);
    step();
    set_in(2'b11, 6'd23, 6'd22, 32'hBBBB_0023, 32'hBBBB_0022);
    step();
    check("st_full_occ", 64'(occupancy), 64'd4);
    stall = 1'b1;
    set_in(2'b11, 6'd31, 6'd30, 32'hEEEE_0031, 32'hEEEE_0030);
    step();
    check("st_hold1_data", outData, {32'hAAAA_0021, 32'hAAAA_0020});
    set_flush(1'b1, 6'd22, 6'd23);
    step();
    exp_fc = exp_fc + 1;
    set_flush(1'b0, 6'd0, 6'd0);
    check("st_hold2_valid", 64'(outValid), 64'b11);
    check("st_hold2_ptr", 64'(outPtr), 64'({6'd21, 6'd20}));
    check("st_flush_occ", 64'(occupancy), 64'd3);
    check_fc("st_fc");
    step();
    check("st_hold3_data", outData, {32'hAAAA_0021, 32'hAAAA_0020});
    stall = 1'b0;
    set_in(2'b00, 6'd0, 6'd0, 32'h0, 32'h0);
    step();
    check("st_rel_valid", 64'(outValid), 64'b10);
    check("st_rel_data", outData, {32'hBBBB_0023, 32'hBBBB_0022});
    step();
    check("st_no_ghost", 64'(outValid), 64'd0);
    check("st_empty_occ", 64'(occupancy), 64'd0);

    // Clear wins over a flush that would hit everything
    set_in(2'b11, 6'd41, 6'd40, 32'h41, 32'h40);
    step();
    step();
    clear = 1'b1;
    set_flush(1'b1, 6'd0, 6'd63);
    step();
    clear = 1'b0;
    set_flush(1'b0, 6'd0, 6'd0);
    set_in(2'b00, 6'd0, 6'd0, 32'h0, 32'h0);
    check("clr_valid", 64'(outValid), 64'd0);
    check("clr_occ", 64'(occupancy), 64'd0);
    check_fc("clr_fc");

    // Reset mid-stream, then fresh latency
    set_in(2'b11, 6'd51, 6'd50, 32'h51, 32'h50);
    step();
    step();
    rst = 1'b1;
    step();
    exp_fc = 0;
    check("mrst_valid", 64'(outValid), 64'd0);
    check("mrst_ptr", 64'(outPtr), 64'd0);
    check("mrst_data", outData, 64'd0);
    check("mrst_occ", 64'(occupancy), 64'd0);
    check_fc("mrst_fc");
    rst = 1'b0;
    set_in(2'b01, 6'd0, 6'd9, 32'h0, 32'h99);
    step();
    set_in(2'b00, 6'd0, 6'd0, 32'h0, 32'h0);
    check("post_rst_c1", 64'(outValid), 64'd0);
    step();
    check("post_rst_c2", 64'(outValid), 64'b01);
    check("post_rst_data", outData[31:0], 64'h99);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
